// File: rtl/pipelined_booth_mul_pkg.sv
// Shared types and constants for the 16x16 radix-4 Booth / Wallace multiplier.
//   WIDTH      operand width (16)
//   PROD_W     product width (32)
//   NUM_PP     Booth partial products (9, covering the 18-bit extended multiplier)
//   EXT_W      extended operand width (18)
//   PP_W       partial-product row width before placement (19, holds +/-2X)
//   SEXT_CONST sign-extension prevention constant, merged with the +1 correction bits
package pipelined_booth_mul_pkg;

  localparam int WIDTH    = 16;
  localparam int PROD_W   = 2 * WIDTH;
  localparam int NUM_PP   = 9;
  localparam int EXT_W    = 18;
  localparam int PP_W     = EXT_W + 1;
  localparam int NUM_ROWS = NUM_PP + 1;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

  typedef logic [PP_W-1:0] pp_array_t [NUM_PP];

  // Each row is stored with its sign bit inverted, which adds 2^(PP_W-1) at the
  // row's weight. This constant subtracts all of those offsets back out. Its
  // low bits are zero, so the correction bits can be OR-ed into the same row.
  function automatic logic [PROD_W-1:0] sext_comp_const();
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      acc = acc + (PROD_W'(1) << (PP_W - 1 + 2 * i));
    end
    return ~acc + PROD_W'(1);
  endfunction

  localparam logic [PROD_W-1:0] SEXT_CONST = sext_comp_const();

  function automatic booth_digit_t booth_decode(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

  function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] a, b, c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] a, b, c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial-product row.
//   window  3-bit Booth window {y[2i+1], y[2i], y[2i-1]}
//   x_ext   18-bit extended multiplicand
//   row     19-bit row: 0, X, 2X or their one's complement
//   neg     1 when the row was complemented; the +1 is added in the tree
module booth_pp_gen
  import pipelined_booth_mul_pkg::*;
(
  input  logic [2:0]       window,
  input  logic [EXT_W-1:0] x_ext,
  output logic [PP_W-1:0]  row,
  output logic             neg
);

  booth_digit_t    digit;
  logic [PP_W-1:0] x1;
  logic [PP_W-1:0] x2;

  assign digit = booth_decode(window);
  assign x1    = {x_ext[EXT_W-1], x_ext};
  assign x2    = {x_ext, 1'b0};

  always_comb begin
    row = '0;
    neg = 1'b0;
    case (digit)
      POS1: row = x1;
      POS2: row = x2;
      NEG1: begin
        row = ~x1;
        neg = 1'b1;
      end
      NEG2: begin
        row = ~x2;
        neg = 1'b1;
      end
      default: row = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_radix4_booth_wallace16.sv
// Four-stage 16x16 -> 32 signed/unsigned multiplier.
//   stage 1: capture operands and signedFlag
//   stage 2: Booth recode, register 9 partial products + correction bits
//   stage 3: Wallace 3:2 tree down to sum/carry
//   stage 4: carry-propagate add into out
// Ports:
//   clk, rst_n (async, active low), run (global advance enable),
//   signedFlag, multiplicand[15:0], multiplier[15:0], out[31:0]
//   out_valid (only when PIPELINED_BOOTH_MUL_VALID_EN is defined)
module pipelined_radix4_booth_wallace16 #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               signedFlag,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] out
`ifdef PIPELINED_BOOTH_MUL_VALID_EN
  ,
  output logic               out_valid
`endif
);

  import pipelined_booth_mul_pkg::*;

  if (WIDTH != 16 || STAGES != 4) begin : g_cfg_check
    $error("pipelined_radix4_booth_wallace16 supports only WIDTH=16, STAGES=4");
  end

  // stage 1
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_sgn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x   <= '0;
      s1_y   <= '0;
      s1_sgn <= 1'b0;
    end else if (run) begin
      s1_x   <= multiplicand;
      s1_y   <= multiplier;
      s1_sgn <= signedFlag;
    end
  end

  // stage 2: recoding
  logic [EXT_W-1:0]  x_ext;
  logic [EXT_W-1:0]  y_ext;
  logic [EXT_W:0]    y_win;
  pp_array_t         pp_d;
  pp_array_t         s2_pp;
  logic [NUM_PP-1:0] neg_d;
  logic [NUM_PP-1:0] s2_neg;

  assign x_ext = {{(EXT_W-WIDTH){s1_sgn & s1_x[WIDTH-1]}}, s1_x};
  assign y_ext = {{(EXT_W-WIDTH){s1_sgn & s1_y[WIDTH-1]}}, s1_y};
  assign y_win = {y_ext, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen u_pp (
      .window (y_win[2*i+2 -: 3]),
      .x_ext  (x_ext),
      .row    (pp_d[i]),
      .neg    (neg_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PP; i++) s2_pp[i] <= '0;
      s2_neg <= '0;
    end else if (run) begin
      s2_pp  <= pp_d;
      s2_neg <= neg_d;
    end
  end

  // stage 3: row placement and Wallace reduction 10 -> 7 -> 5 -> 4 -> 3 -> 2
  logic [PROD_W-1:0] l0 [NUM_ROWS];
  logic [PROD_W-1:0] l1 [7];
  logic [PROD_W-1:0] l2 [5];
  logic [PROD_W-1:0] l3 [4];
  logic [PROD_W-1:0] l4 [3];
  logic [PROD_W-1:0] corr_row;
  logic [PROD_W-1:0] sum_d;
  logic [PROD_W-1:0] carry_d;
  logic [PROD_W-1:0] s3_sum;
  logic [PROD_W-1:0] s3_carry;

  // sign bit inverted; bits shifted past bit 31 drop out (mod 2^32)
  for (genvar i = 0; i < NUM_PP; i++) begin : g_row
    assign l0[i] = {{(PROD_W-PP_W){1'b0}}, ~s2_pp[i][PP_W-1], s2_pp[i][PP_W-2:0]} << (2*i);
  end

  always_comb begin
    corr_row = SEXT_CONST;
    for (int i = 0; i < NUM_PP; i++) corr_row[2*i] = s2_neg[i];
  end
  assign l0[NUM_PP] = corr_row;

  for (genvar g = 0; g < 3; g++) begin : g_l1
    assign l1[2*g]   = csa_sum  (l0[3*g], l0[3*g+1], l0[3*g+2]);
    assign l1[2*g+1] = csa_carry(l0[3*g], l0[3*g+1], l0[3*g+2]);
  end
  assign l1[6] = l0[9];

  for (genvar g = 0; g < 2; g++) begin : g_l2
    assign l2[2*g]   = csa_sum  (l1[3*g], l1[3*g+1], l1[3*g+2]);
    assign l2[2*g+1] = csa_carry(l1[3*g], l1[3*g+1], l1[3*g+2]);
  end
  assign l2[4] = l1[6];

  assign l3[0] = csa_sum  (l2[0], l2[1], l2[2]);
  assign l3[1] = csa_carry(l2[0], l2[1], l2[2]);
  assign l3[2] = l2[3];
  assign l3[3] = l2[4];

  assign l4[0] = csa_sum  (l3[0], l3[1], l3[2]);
  assign l4[1] = csa_carry(l3[0], l3[1], l3[2]);
  assign l4[2] = l3[3];

  assign sum_d   = csa_sum  (l4[0], l4[1], l4[2]);
  assign carry_d = csa_carry(l4[0], l4[1], l4[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_sum   <= '0;
      s3_carry <= '0;
    end else if (run) begin
      s3_sum   <= sum_d;
      s3_carry <= carry_d;
    end
  end

  // stage 4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (run) begin
      out <= s3_sum + s3_carry;
    end
  end

`ifdef PIPELINED_BOOTH_MUL_VALID_EN
  logic [STAGES-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (run) begin
      vld <= {vld[STAGES-2:0], 1'b1};
    end
  end

  assign out_valid = vld[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_radix4_booth_wallace16.sv
// Scoreboard bench for pipelined_radix4_booth_wallace16: the driver pushes the
// expected product when it issues a vector; the monitor tracks which run edges
// carried a vector and pops/compares when that vector reaches out.
module tb_pipelined_radix4_booth_wallace16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        signedFlag;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] out;
`ifdef PIPELINED_BOOTH_MUL_VALID_EN
  logic        out_valid;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic        issued;

  logic [15:0] grid [12] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h7FFF, 16'h8000,
                             16'h8001, 16'hFFFF, 16'h1234, 16'hABCD, 16'h00FF, 16'hFF00};

  pipelined_radix4_booth_wallace16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .signedFlag   (signedFlag),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out          (out)
`ifdef PIPELINED_BOOTH_MUL_VALID_EN
    ,
    .out_valid    (out_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int     sa, sb;
    longint ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'(a);
    ub = longint'(b);
    if (s) return 32'(sa * sb);
    return 32'(ua * ub);
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] want);
    multiplicand = a;
    multiplier   = b;
    signedFlag   = s;
    run          = 1'b1;
    issued       = 1'b1;
    exp_q.push_back(want);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    multiplicand = '0;
    multiplier   = '0;
    signedFlag   = 1'b0;
    run          = 1'b1;
    issued       = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic stall(input int n);
    run    = 1'b0;
    issued = 1'b0;
    repeat (n) begin
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
      signedFlag   = 1'($urandom);
      @(negedge clk);
    end
  endtask

  // monitor
  initial begin : monitor
    logic        r;
    logic        iss;
    logic [3:0]  vp;
    logic [31:0] held;
    logic [31:0] e;
    int          run_edges;
    vp        = '0;
    held      = '0;
    run_edges = 0;
    forever begin
      @(posedge clk);
      r   = run;
      iss = issued;
      #1;
      if (!rst_n) begin
        vp        = '0;
        held      = '0;
        run_edges = 0;
        exp_q.delete();
      end else begin
        if (r) begin
          vp = {vp[2:0], iss};
          run_edges++;
          e = 32'h0;
          if (vp[3]) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL scoreboard_underflow: got empty queue, expected an entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
            end
          end
          held = e;
        end
        check("out", out, held);
`ifdef PIPELINED_BOOTH_MUL_VALID_EN
        check("out_valid", {31'b0, out_valid}, (run_edges >= 4) ? 32'd1 : 32'd0);
`endif
      end
    end
  end

  initial begin : stim
    rst_n        = 1'b0;
    run          = 1'b0;
    issued       = 1'b0;
    signedFlag   = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    check("reset_out", out, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // unsigned back-to-back stream
    issue(16'h0000, 16'h0000, 1'b0, 32'h0000_0000);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    issue(16'h8000, 16'h7FFF, 1'b0, 32'h3FFF_8000);
    issue(16'h0003, 16'h0005, 1'b0, 32'h0000_000F);
    // signed
    issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    issue(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    issue(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
    issue(16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE);
    // flag changes per cycle
    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    issue(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001);
    issue(16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF);
    // stall mid-flight
    issue(16'd7,   16'd9,   1'b0, 32'd63);
    issue(16'd100, 16'd100, 1'b0, 32'd10000);
    stall(3);
    idle(6);

    // async reset mid-stream
    issue(16'h1234, 16'h0010, 1'b0, 32'h0001_2340);
    issue(16'h0101, 16'h0101, 1'b0, 32'h0001_0201);
    issue(16'h0400, 16'h0400, 1'b0, 32'h0010_0000);
    issue(16'h0011, 16'h0011, 1'b0, 32'h0000_0121);
    issue(16'h0002, 16'h0003, 1'b0, 32'h0000_0006);
    issue(16'h0010, 16'h0010, 1'b0, 32'h0000_0100);
    #2 rst_n = 1'b0;
    #1 check("reset_async_out", out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h00FF, 16'h0101, 1'b0, 32'h0000_FFFF);
    idle(6);

    // stepped grid, both modes
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 12; i++)
        for (int j = 0; j < 12; j++)
          issue(grid[i], grid[j], s[0], model(grid[i], grid[j], s[0]));

    // random vectors with occasional stalls
    for (int k = 0; k < 200; k++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      issue(a, b, s, model(a, b, s));
      if (k % 37 == 5) stall(2);
    end
    idle(6);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_radix4_booth_wallace16.md
Name: pipelined_radix4_booth_wallace16

Overview:
- 16x16 -> 32-bit multiplier, four pipeline stages, one result accepted per clock.
- Product is signed or unsigned, selected per operation.
- Datapath: radix-4 (modified) Booth recoding, Wallace-tree carry-save reduction, final carry-propagate add.
- Used as the integer multiply unit in the ALU/FPU datapath; free-running stream with a global advance enable (`run`), no handshake back-pressure.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported; the product width is 2*WIDTH = 32.
- STAGES, 4, number of pipeline register stages. Informational; fixed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  pipeline advance enable; 1 = all stages shift, 0 = all stages hold
- signedFlag  input  1  1 = both operands two's complement; 0 = both unsigned
- multiplicand  input  16  operand X
- multiplier  input  16  operand Y
- out  output  32  registered product

Behaviour:
- Reset: rst_n low asynchronously clears every pipeline register, including the captured flag and `out`. `out` = 32'h0 during reset and after release until results arrive.
- Stage 1, edge k with run=1: register multiplicand, multiplier and signedFlag.
  - signedFlag travels with its operands.
  - A flag change takes effect only for operands captured on the same edge; in-flight results are unaffected.
- Stage 2, edge k+1:
  - Extend Y to 18 bits: sign-extend if the flag is set, zero-extend otherwise.
  - Append an implicit 0 below bit 0 and Booth-recode into 9 digits in {-2,-1,0,+1,+2}.
  - Extend X the same way; form 9 partial products (0, ±X, ±2X).
  - Negation is one's complement plus a +1 correction bit injected at the partial product's LSB weight.
  - Sign-extension prevention constants are used so every row fits 32 bits.
  - Register the partial products and correction bits.
- Stage 3, edge k+2: Wallace tree of 3:2 (and 2:2 where needed) compressors reduces all rows to two 32-bit vectors (sum, carry); register them.
- Stage 4, edge k+3: `out` <= (sum + carry) mod 2^32.
- Latency: operands sampled on edge k appear on `out` immediately after edge k+3. Throughput 1/cycle.
- Arithmetic:
  - Unsigned mode: out = X*Y, exact, max 0xFFFE0001.
  - Signed mode: out = two's-complement 32-bit X*Y; every 16-bit signed pair is exact, including -32768*-32768 = 0x40000000.
- run=0: no register changes; `out` holds its last value. Resuming run continues the stream with no loss or duplication.
- Inputs are don't-care on edges where run=0.
- Reset mid-operation: all in-flight results are discarded; `out` goes to 0 immediately.
- No internal state besides the pipeline; no overflow or status outputs.

Optional Feature:
- Macro PIPELINED_BOOTH_MUL_VALID_EN.
- Defined:
  - Add output `out_valid` (1 bit).
  - A 4-deep valid shift register loads 1 when an operand is captured (run=1) and advances only when run=1.
  - `out_valid` marks that `out` holds a real product; it is cleared by rst_n.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package pipelined_booth_mul_pkg: WIDTH=16, PROD_W=32, NUM_PP=9, EXT_W=18, a Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2), and a typedef for the partial-product array.
- One natural sub-module: booth_pp_gen. It takes a 3-bit Booth window and extended X and returns a row plus a negate bit; instantiate 9 times.
- The compressor tree stays inline in the top as generate loops.

Test Plan:
- Unsigned stream, run held 1: back-to-back (0,0), (0xFFFF,0xFFFF), (0x8000,0x7FFF), (3,5) -> `out` after 4th edge = 0x00000000, 0xFFFE0001, 0x3FFF8000, 0x0000000F on consecutive cycles.
- Signed mode: (0xFFFF,0xFFFF) -> 0x00000001; (0x8000,0x8000) -> 0x40000000; (0x8000,0x7FFF) -> 0xC0008000; (0xFFFF,0x0002) -> 0xFFFFFFFE.
- Mixed flag per cycle, unsigned then signed of (0xFFFF,0xFFFF) -> 0xFFFE0001 then 0x00000001, no cross-contamination.
- Stall: issue A=(7,9) and B=(100,100), drop run for 3 cycles mid-flight, then resume -> `out` frozen during the stall; 63 and then 10000 appear with no duplicate or missing result.
- Reset: assert rst_n low mid-stream between clock edges -> `out`=0 immediately; first result after release appears 4 run-edges after its capture.
- Exhaustive/random sweep: stepped grid over both operand ranges in both modes, compared against a behavioural product delayed 4 stages -> zero mismatches.
